// File: rtl/core_ctrl_pkg.sv
//==============================================================================
// core_ctrl_pkg : shared types and defaults for the core run/step/halt sequencer
// Revision 1.0
//==============================================================================
`default_nettype none

package core_ctrl_pkg;

  localparam int PC_W_DEFAULT  = 9;
  localparam int CNT_W_DEFAULT = 32;

  // ST_STEP is internal only; it is reported to the outside world as RUN.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_RUN    = 3'd1,
    ST_HALTED = 3'd2,
    ST_DONE   = 3'd3,
    ST_STEP   = 3'd4
  } state_e;

  typedef enum logic [1:0] {
    RSN_NONE  = 2'd0,
    RSN_HOST  = 2'd1,
    RSN_BREAK = 2'd2,
    RSN_STEP  = 2'd3
  } reason_e;

  function automatic logic [1:0] state_code(input state_e s);
    logic [1:0] code;
    case (s)
      ST_IDLE:   code = 2'd0;
      ST_RUN:    code = 2'd1;
      ST_STEP:   code = 2'd1;
      ST_HALTED: code = 2'd2;
      ST_DONE:   code = 2'd3;
      default:   code = 2'd0;
    endcase
    return code;
  endfunction

endpackage : core_ctrl_pkg

`default_nettype wire

// File: rtl/core_run_ctrl_if.sv
//==============================================================================
// core_run_ctrl_if : command, core-PC and status bundle of the run controller
// Revision 1.0
//==============================================================================
`default_nettype none

interface core_run_ctrl_if
  import core_ctrl_pkg::*;
#(
  parameter int PC_W  = PC_W_DEFAULT,
  parameter int CNT_W = CNT_W_DEFAULT
);

  logic             run_i;
  logic             step_i;
  logic             halt_i;
  logic             bp_en_i;
  logic [PC_W-1:0]  bp_addr_i;
  logic [PC_W-1:0]  pc_i;
  logic [PC_W-1:0]  pc_next_i;
  logic             en_o;
  logic [1:0]       state_o;
  logic [1:0]       reason_o;
  logic             done_o;
  logic [CNT_W-1:0] instr_cnt_o;
  logic [CNT_W-1:0] cycle_cnt_o;

  modport master (
    output run_i, step_i, halt_i, bp_en_i, bp_addr_i, pc_i, pc_next_i,
    input  en_o, state_o, reason_o, done_o, instr_cnt_o, cycle_cnt_o
  );

  modport slave (
    input  run_i, step_i, halt_i, bp_en_i, bp_addr_i, pc_i, pc_next_i,
    output en_o, state_o, reason_o, done_o, instr_cnt_o, cycle_cnt_o
  );

endinterface : core_run_ctrl_if

`default_nettype wire

// File: rtl/sat_counter.sv
//==============================================================================
// sat_counter : up-counter that sticks at all-ones instead of wrapping
// Revision 1.0
//==============================================================================
`default_nettype none

module sat_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             inc_i,
  output logic [WIDTH-1:0] cnt_o
);

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc_i && !(&cnt_q)) begin
      cnt_d = cnt_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule : sat_counter

`default_nettype wire

// File: rtl/core_run_ctrl.sv
//==============================================================================
// core_run_ctrl : run/step/halt sequencer gating the single-cycle core's commit
// Revision 1.0
//==============================================================================
`default_nettype none

module core_run_ctrl
  import core_ctrl_pkg::*;
#(
  parameter int PC_W  = PC_W_DEFAULT,
  parameter int CNT_W = CNT_W_DEFAULT
) (
  input  logic            clk_i,
  input  logic            rst_i,
  core_run_ctrl_if.slave  bus
);

  state_e           state_q;
  state_e           state_d;
  reason_e          reason_q;
  reason_e          reason_d;
  logic             skip_bp_q;
  logic             skip_bp_d;

  logic [PC_W-1:0]  pc;
  logic [PC_W-1:0]  pc_next;
  logic [PC_W-1:0]  bp_addr;
  logic             bp_hit;
  logic             en;
  logic             self_loop;
  logic             in_run;
  logic [CNT_W-1:0] instr_cnt;
  logic [CNT_W-1:0] cycle_cnt;

  assign pc      = bus.pc_i;
  assign pc_next = bus.pc_next_i;
  assign bp_addr = bus.bp_addr_i;

  // skip_bp lets a resume from a breakpoint retire the instruction sitting on it.
  assign bp_hit    = bus.bp_en_i & (pc == bp_addr) & ~skip_bp_q;
  assign en        = rst_i & (((state_q == ST_RUN) & ~bp_hit) | (state_q == ST_STEP));
  assign self_loop = en & (pc_next == pc);
  assign in_run    = (state_q == ST_RUN);

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q   <= ST_IDLE;
      reason_q  <= RSN_NONE;
      skip_bp_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      reason_q  <= reason_d;
      skip_bp_q <= skip_bp_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    reason_d  = reason_q;
    skip_bp_d = skip_bp_q;
    if (en) begin
      skip_bp_d = 1'b0;
    end
    case (state_q)
      ST_IDLE, ST_HALTED: begin
        if (!bus.halt_i) begin
          if (bus.step_i) begin
            state_d   = ST_STEP;
            skip_bp_d = 1'b1;
          end else if (bus.run_i) begin
            state_d   = ST_RUN;
            skip_bp_d = 1'b1;
          end
        end
      end
      ST_STEP: begin
        if (self_loop) begin
          state_d = ST_DONE;
        end else begin
          state_d  = ST_HALTED;
          reason_d = RSN_STEP;
        end
      end
      ST_RUN: begin
        // Program end outranks a same-cycle halt or breakpoint.
        if (self_loop) begin
          state_d = ST_DONE;
        end else if (bus.halt_i) begin
          state_d  = ST_HALTED;
          reason_d = RSN_HOST;
        end else if (bp_hit) begin
          state_d  = ST_HALTED;
          reason_d = RSN_BREAK;
        end
      end
      ST_DONE: begin
        state_d = ST_DONE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_comb begin
    bus.en_o        = en;
    bus.state_o     = state_code(state_q);
    bus.reason_o    = reason_q;
    bus.done_o      = (state_q == ST_DONE);
    bus.instr_cnt_o = instr_cnt;
    bus.cycle_cnt_o = cycle_cnt;
  end

  sat_counter #(
    .WIDTH (CNT_W)
  ) u_instr_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .inc_i (en),
    .cnt_o (instr_cnt)
  );

  sat_counter #(
    .WIDTH (CNT_W)
  ) u_cycle_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .inc_i (in_run),
    .cnt_o (cycle_cnt)
  );

endmodule : core_run_ctrl

`default_nettype wire

// File: tb/tb_core_run_ctrl.sv
//==============================================================================
// tb_core_run_ctrl : per-cycle vector table plus saturation/reset/timeout sequences
// Revision 1.0
//==============================================================================
`default_nettype none

module tb_core_run_ctrl;

  localparam int PC_W  = 9;
  localparam int CNT_W = 4;

  typedef struct {
    logic       rst_n;
    logic [2:0] cmd;      // {halt, step, run}
    logic       bp_en;
    logic [8:0] bp_addr;
    logic [8:0] end_pc;
    logic       en;
    logic [1:0] st;
    logic [1:0] rs;
    logic       done;
    logic [3:0] ic;
    logic [3:0] cc;
  } vec_t;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [PC_W-1:0] pc;
  logic [PC_W-1:0] end_pc;
  vec_t            vec [48];
  int              nv = 0;
  int              checks = 0;
  int              failures = 0;

  always #5 clk = ~clk;

  core_run_ctrl_if #(.PC_W(PC_W), .CNT_W(CNT_W)) bus ();

  core_run_ctrl #(.PC_W(PC_W), .CNT_W(CNT_W)) dut (
    .clk_i (clk),
    .rst_i (rst_n),
    .bus   (bus)
  );

  // Tiny core: sequential ADDs at +4, a jump-to-self at end_pc.
  assign bus.pc_i      = pc;
  assign bus.pc_next_i = (pc == end_pc) ? pc : pc + PC_W'(4);

  always @(posedge clk) begin
    if (!rst_n) pc <= '0;
    else if (bus.en_o) pc <= bus.pc_next_i;
  end

  task automatic add(input logic r, input logic [2:0] c, input logic be, input logic [8:0] ba,
                     input logic [8:0] ep, input logic e, input logic [1:0] st, input logic [1:0] rs,
                     input logic d, input logic [3:0] ic, input logic [3:0] cc);
    vec[nv] = '{rst_n: r, cmd: c, bp_en: be, bp_addr: ba, end_pc: ep,
                en: e, st: st, rs: rs, done: d, ic: ic, cc: cc};
    nv++;
  endtask

  task automatic apply(input int idx);
    vec_t v;
    v = vec[idx];
    @(posedge clk);
    #1;
    rst_n         = v.rst_n;
    bus.halt_i    = v.cmd[2];
    bus.step_i    = v.cmd[1];
    bus.run_i     = v.cmd[0];
    bus.bp_en_i   = v.bp_en;
    bus.bp_addr_i = v.bp_addr;
    end_pc        = v.end_pc;
    @(negedge clk);
    checks++;
    if ({bus.en_o, bus.state_o, bus.reason_o, bus.done_o, bus.instr_cnt_o, bus.cycle_cnt_o} !==
        {v.en, v.st, v.rs, v.done, v.ic, v.cc}) begin
      failures++;
      $display("FAIL vec%0d got en=%b st=%0d rs=%0d done=%b ic=%0d cc=%0d exp en=%b st=%0d rs=%0d done=%b ic=%0d cc=%0d",
               idx, bus.en_o, bus.state_o, bus.reason_o, bus.done_o, bus.instr_cnt_o, bus.cycle_cnt_o,
               v.en, v.st, v.rs, v.done, v.ic, v.cc);
    end
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", name, got, exp);
    end
  endtask

  initial begin
    int n_en;
    int cyc;
    rst_n         = 1'b0;
    bus.run_i     = 1'b0;
    bus.step_i    = 1'b0;
    bus.halt_i    = 1'b0;
    bus.bp_en_i   = 1'b0;
    bus.bp_addr_i = '0;
    end_pc        = 9'd8;
    @(posedge clk);

    //   rst cmd    bpen bpa ep   en st rs d ic cc
    // Program 0,4,8(self) runs to DONE; DONE then ignores every command.
    add(1, 3'b000, 0, 0, 8,   0, 0, 0, 0, 0, 0);
    add(1, 3'b001, 0, 0, 8,   0, 0, 0, 0, 0, 0);
    add(1, 3'b000, 0, 0, 8,   1, 1, 0, 0, 0, 0);
    add(1, 3'b000, 0, 0, 8,   1, 1, 0, 0, 1, 1);
    add(1, 3'b000, 0, 0, 8,   1, 1, 0, 0, 2, 2);
    add(1, 3'b001, 0, 0, 8,   0, 3, 0, 1, 3, 3);
    add(1, 3'b010, 0, 0, 8,   0, 3, 0, 1, 3, 3);
    add(1, 3'b100, 0, 0, 8,   0, 3, 0, 1, 3, 3);
    add(1, 3'b111, 0, 0, 8,   0, 3, 0, 1, 3, 3);
    add(0, 3'b000, 0, 0, 8,   0, 3, 0, 1, 3, 3);
    // Breakpoint at 8 stops before it; resume retires it once and runs to 12(self).
    add(1, 3'b001, 1, 8, 12,  0, 0, 0, 0, 0, 0);
    add(1, 3'b000, 1, 8, 12,  1, 1, 0, 0, 0, 0);
    add(1, 3'b000, 1, 8, 12,  1, 1, 0, 0, 1, 1);
    add(1, 3'b000, 1, 8, 12,  0, 1, 0, 0, 2, 2);
    add(1, 3'b000, 1, 8, 12,  0, 2, 2, 0, 2, 3);
    add(1, 3'b001, 1, 8, 12,  0, 2, 2, 0, 2, 3);
    add(1, 3'b000, 1, 8, 12,  1, 1, 2, 0, 2, 3);
    add(1, 3'b000, 1, 8, 12,  1, 1, 2, 0, 3, 4);
    add(1, 3'b000, 1, 8, 12,  0, 3, 2, 1, 4, 5);
    add(0, 3'b000, 1, 8, 12,  0, 3, 2, 1, 4, 5);
    // Halt in IDLE is a no-op; two steps give two isolated enables; step ignores bp.
    add(1, 3'b100, 0, 0, 200, 0, 0, 0, 0, 0, 0);
    add(1, 3'b010, 0, 0, 200, 0, 0, 0, 0, 0, 0);
    add(1, 3'b000, 0, 0, 200, 1, 1, 0, 0, 0, 0);
    add(1, 3'b000, 0, 0, 200, 0, 2, 3, 0, 1, 0);
    add(1, 3'b010, 0, 0, 200, 0, 2, 3, 0, 1, 0);
    add(1, 3'b000, 0, 0, 200, 1, 1, 3, 0, 1, 0);
    add(1, 3'b000, 0, 0, 200, 0, 2, 3, 0, 2, 0);
    add(1, 3'b010, 1, 8, 200, 0, 2, 3, 0, 2, 0);
    add(1, 3'b000, 1, 8, 200, 1, 1, 3, 0, 2, 0);
    add(1, 3'b000, 0, 0, 200, 0, 2, 3, 0, 3, 0);
    // Halt+step+run together in RUN: halt wins and that cycle's instruction retires.
    add(1, 3'b001, 0, 0, 200, 0, 2, 3, 0, 3, 0);
    add(1, 3'b000, 0, 0, 200, 1, 1, 3, 0, 3, 0);
    add(1, 3'b111, 0, 0, 200, 1, 1, 3, 0, 4, 1);
    add(1, 3'b000, 0, 0, 200, 0, 2, 1, 0, 5, 2);
    // Step while running is ignored; reset mid-RUN drops en_o immediately.
    add(1, 3'b001, 0, 0, 200, 0, 2, 1, 0, 5, 2);
    add(1, 3'b010, 0, 0, 200, 1, 1, 1, 0, 5, 2);
    add(1, 3'b000, 0, 0, 200, 1, 1, 1, 0, 6, 3);
    add(0, 3'b000, 0, 0, 200, 0, 1, 1, 0, 7, 4);
    add(1, 3'b000, 0, 0, 200, 0, 0, 0, 0, 0, 0);

    for (int i = 0; i < nv; i++) begin
      apply(i);
    end

    // 20 free-running instructions saturate both 4-bit counters at 15.
    @(posedge clk);
    #1;
    end_pc    = 9'd400;
    bus.run_i = 1'b1;
    @(posedge clk);
    #1;
    bus.run_i = 1'b0;
    n_en = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.en_o) n_en++;
    end
    check("sat_en_cycles", n_en, 20);
    check("sat_instr_cnt", bus.instr_cnt_o, 15);
    check("sat_cycle_cnt", bus.cycle_cnt_o, 15);
    check("sat_state", bus.state_o, 1);

    rst_n = 1'b0;
    #1;
    check("rst_cycle_en", bus.en_o, 0);
    @(posedge clk);
    #1;
    check("rst_state", bus.state_o, 0);
    check("rst_reason", bus.reason_o, 0);
    check("rst_done", bus.done_o, 0);
    check("rst_counters", {bus.instr_cnt_o, bus.cycle_cnt_o}, 0);

    // Run 0..40(self) to completion under a cycle budget.
    rst_n     = 1'b1;
    end_pc    = 9'd40;
    bus.run_i = 1'b1;
    @(posedge clk);
    #1;
    bus.run_i = 1'b0;
    cyc = 0;
    while (!bus.done_o && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    check("prog_done_within_budget", bus.done_o, 1);
    check("prog_state", bus.state_o, 3);
    check("prog_instr_cnt", bus.instr_cnt_o, 11);
    check("prog_cycle_cnt", bus.cycle_cnt_o, 11);
    check("prog_final_pc", pc, 40);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_core_run_ctrl

`default_nettype wire
